// File: rtl/vred_if.sv
// Reduction sequencer bus: dispatch request, register-file read port,
// and the beat stream and retire strobe of the reduction unit.
interface vred_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int VL_WIDTH   = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_vs2_addr;
  logic [ADDR_WIDTH-1:0] req_vd_addr;
  logic [VL_WIDTH-1:0]   req_vl;
  logic [1:0]            req_sew;
  logic [2:0]            req_opsel;
  logic                  req_lop_sum;
  logic [DATA_WIDTH-1:0] req_seed;

  logic                  rf_rd_en;
  logic [ADDR_WIDTH-1:0] rf_rd_addr;
  logic [DATA_WIDTH-1:0] rf_rd_data;

  logic                  red_in_valid;
  logic                  red_in_start;
  logic                  red_in_end;
  logic                  red_in_lop_sum;
  logic [DATA_WIDTH-1:0] red_in_vec0;
  logic [DATA_WIDTH-1:0] red_in_vec1;
  logic [2:0]            red_in_opSel;
  logic [1:0]            red_in_sew;
  logic [ADDR_WIDTH-1:0] red_in_addr;
  logic                  red_out_valid;

  logic                  busy;
  logic                  done;
  logic                  err;

  modport slave (
    input  req_valid, req_vs2_addr, req_vd_addr, req_vl,
    input  req_sew, req_opsel, req_lop_sum, req_seed,
    input  rf_rd_data, red_out_valid,
    output req_ready, rf_rd_en, rf_rd_addr,
    output red_in_valid, red_in_start, red_in_end,
    output red_in_lop_sum, red_in_vec0, red_in_vec1,
    output red_in_opSel, red_in_sew, red_in_addr,
    output busy, done, err
  );

  modport master (
    output req_valid, req_vs2_addr, req_vd_addr, req_vl,
    output req_sew, req_opsel, req_lop_sum, req_seed,
    output rf_rd_data, red_out_valid,
    input  req_ready, rf_rd_en, rf_rd_addr,
    input  red_in_valid, red_in_start, red_in_end,
    input  red_in_lop_sum, red_in_vec0, red_in_vec1,
    input  red_in_opSel, red_in_sew, red_in_addr,
    input  busy, done, err
  );
endinterface

// File: rtl/vred_sequencer.sv
// Issue controller for the vector reduction datapath: streams source rows
// into the reduction unit with framing and identity padding of the tail.
module vred_sequencer #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 32,
  parameter int VL_WIDTH      = 16,
  parameter bit ENABLE_64_BIT = 1'b0,
  parameter int RED_LATENCY   = 6
) (
  input logic  clk,
  input logic  rst,
  vred_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LOGB  = $clog2(BYTES);

  if (BYTES < 8 || RED_LATENCY < 1) begin : g_bad_param
    $error("vred_sequencer: unsupported parameters");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] vs2_q, vd_q;
  logic [1:0]            sew_q;
  logic [2:0]            opsel_q;
  logic                  lop_q, err_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [VL_WIDTH-1:0]   nm1_q, last_q, cnt_q;
  logic                  pend_q, pend_first_q, pend_last_q;

  logic [2:0]          sh;
  logic [VL_WIDTH-1:0] vl_m1, epb, nm1, last_n;
  logic                illegal, accept, rd_en;

  assign sh      = 3'(LOGB) - {1'b0, bus.req_sew};
  assign vl_m1   = bus.req_vl - VL_WIDTH'(1);
  assign epb     = VL_WIDTH'(BYTES) >> bus.req_sew;
  assign nm1     = vl_m1 >> sh;
  assign last_n  = (vl_m1 & (epb - VL_WIDTH'(1))) + VL_WIDTH'(1);
  assign illegal = (bus.req_sew == 2'd3 && !ENABLE_64_BIT)
                || (bus.req_lop_sum && bus.req_opsel[1:0] == 2'b00)
                || (!bus.req_lop_sum && bus.req_opsel[2:1] == 2'b11);
  assign accept  = (state == IDLE) && bus.req_valid;
  assign rd_en   = (state == ISSUE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.req_valid)
               state_nx = (illegal || bus.req_vl == '0) ? DONE : ISSUE;
      ISSUE: if (cnt_q == nm1_q) state_nx = DRAIN;
      DRAIN: if (bus.red_out_valid) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      vs2_q        <= '0;
      vd_q         <= '0;
      sew_q        <= '0;
      opsel_q      <= '0;
      lop_q        <= 1'b0;
      err_q        <= 1'b0;
      seed_q       <= '0;
      nm1_q        <= '0;
      last_q       <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      pend_first_q <= 1'b0;
      pend_last_q  <= 1'b0;
    end else begin
      state        <= state_nx;
      pend_q       <= rd_en;
      pend_first_q <= rd_en && cnt_q == '0;
      pend_last_q  <= rd_en && cnt_q == nm1_q;
      if (rd_en) cnt_q <= cnt_q + VL_WIDTH'(1);
      if (accept) begin
        vs2_q   <= bus.req_vs2_addr;
        vd_q    <= bus.req_vd_addr;
        sew_q   <= bus.req_sew;
        opsel_q <= bus.req_opsel;
        lop_q   <= bus.req_lop_sum;
        seed_q  <= bus.req_seed;
        err_q   <= illegal;
        nm1_q   <= nm1;
        last_q  <= last_n;
        cnt_q   <= '0;
      end
    end
  end

  // Identity bytes: id_hi is the most significant byte of each lane.
  logic [7:0] id_hi, id_lo;
  always_comb begin
    id_hi = 8'h00;
    id_lo = 8'h00;
    unique case (1'b1)
      lop_q && opsel_q[1:0] == 2'b01: begin id_hi = 8'hFF; id_lo = 8'hFF; end
      !lop_q && opsel_q == 3'b010:    begin id_hi = 8'h7F; id_lo = 8'hFF; end
      !lop_q && opsel_q == 3'b011:    begin id_hi = 8'hFF; id_lo = 8'hFF; end
      !lop_q && opsel_q == 3'b100:    begin id_hi = 8'h80; id_lo = 8'h00; end
      default: ;
    endcase
  end

  logic [DATA_WIDTH-1:0] padded;
  always_comb begin
    padded = bus.rf_rd_data;
    for (int b = 0; b < BYTES; b++) begin
      if (pend_last_q && (b >> sew_q) >= int'(last_q))
        padded[b*8 +: 8] = (((b + 1) & ((1 << sew_q) - 1)) == 0) ? id_hi : id_lo;
    end
  end

  logic                  o_valid, o_start, o_end, o_lop;
  logic [DATA_WIDTH-1:0] o_vec0, o_vec1;
  logic [2:0]            o_op;
  logic [1:0]            o_sew;
  logic [ADDR_WIDTH-1:0] o_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || !pend_q) begin
      o_valid <= 1'b0;
      o_start <= 1'b0;
      o_end   <= 1'b0;
      o_lop   <= 1'b0;
      o_vec0  <= '0;
      o_vec1  <= '0;
      o_op    <= '0;
      o_sew   <= '0;
      o_addr  <= '0;
    end else begin
      o_valid <= 1'b1;
      o_start <= pend_first_q;
      o_end   <= pend_last_q;
      o_lop   <= lop_q;
      o_vec0  <= padded;
      o_vec1  <= pend_first_q ? seed_q : '0;
      o_op    <= opsel_q;
      o_sew   <= sew_q;
      o_addr  <= vd_q;
    end
  end

  assign bus.req_ready      = (state == IDLE);
  assign bus.busy           = (state != IDLE);
  assign bus.done           = (state == DONE);
  assign bus.err            = (state == DONE) && err_q;
  assign bus.rf_rd_en       = rd_en;
  assign bus.rf_rd_addr     = rd_en ? vs2_q + ADDR_WIDTH'(cnt_q) : '0;
  assign bus.red_in_valid   = o_valid;
  assign bus.red_in_start   = o_start;
  assign bus.red_in_end     = o_end;
  assign bus.red_in_lop_sum = o_lop;
  assign bus.red_in_vec0    = o_vec0;
  assign bus.red_in_vec1    = o_vec1;
  assign bus.red_in_opSel   = o_op;
  assign bus.red_in_sew     = o_sew;
  assign bus.red_in_addr    = o_addr;
endmodule

// File: tb/tb_vred_sequencer.sv
// Directed bench for vred_sequencer: vector table plus reset-in-drain
// and stale-retire sequences.
module tb_vred_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vred_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .VL_WIDTH(16)) bus ();

  vred_sequencer #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .VL_WIDTH(16),
    .ENABLE_64_BIT(1'b0), .RED_LATENCY(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  logic [63:0] row_val = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.rf_rd_data <= bus.rf_rd_en ? row_val : '0;

  int nrd, nb, ndone, nerr, dirty, rd_first, b_first, done_cyc;
  logic [31:0] rd_addr [16];
  logic [63:0] b_v0 [16];
  logic [63:0] b_v1 [16];
  logic        b_s [16];
  logic        b_e [16];
  logic [2:0]  b0_op;
  logic [1:0]  b0_sew;
  logic [31:0] b0_addr;
  logic        b0_lop;
  logic        ready_at_done;
  bit          seen_end;

  always @(negedge clk) begin
    if (bus.rf_rd_en) begin
      if (nrd < 16) rd_addr[nrd] = bus.rf_rd_addr;
      if (nrd == 0) rd_first = cyc;
      nrd++;
    end
    if (bus.red_in_valid) begin
      if (nb < 16) begin
        b_v0[nb] = bus.red_in_vec0;
        b_v1[nb] = bus.red_in_vec1;
        b_s[nb]  = bus.red_in_start;
        b_e[nb]  = bus.red_in_end;
      end
      if (nb == 0) begin
        b_first = cyc;
        b0_op   = bus.red_in_opSel;
        b0_sew  = bus.red_in_sew;
        b0_addr = bus.red_in_addr;
        b0_lop  = bus.red_in_lop_sum;
      end
      if (bus.red_in_end) seen_end = 1'b1;
      nb++;
    end else if (bus.red_in_start || bus.red_in_end || bus.red_in_lop_sum
                 || |bus.red_in_vec0 || |bus.red_in_vec1
                 || |bus.red_in_opSel || |bus.red_in_sew || |bus.red_in_addr) begin
      dirty++;
    end
    if (bus.done) begin
      ndone++;
      done_cyc = cyc;
      ready_at_done = bus.req_ready;
      if (bus.err) nerr++;
    end else if (bus.err) begin
      dirty++;
    end
  end

  task automatic chk(input string nm, input string what,
                     input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s/%s: got %h want %h", nm, what, act, exp);
    end
  endtask

  task automatic clear_mon();
    nrd = 0; nb = 0; ndone = 0; nerr = 0; dirty = 0;
    rd_first = -1; b_first = -1; done_cyc = -1;
    seen_end = 1'b0; ready_at_done = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    string       nm;
    logic [31:0] vs2;
    logic [15:0] vl;
    logic [1:0]  sew;
    logic [2:0]  op;
    logic        lop;
    logic [63:0] seed;
    logic [63:0] row;
    logic [63:0] last;
    int          n;
    logic        err;
    int          dly;
  } vec_t;

  vec_t tv [12];

  task automatic drive_req(input vec_t v, output int acc);
    int w;
    w = 0;
    while (!bus.req_ready && w < 50) begin tick(); w++; end
    chk(v.nm, "ready", 64'(bus.req_ready), 64'd1);
    bus.req_vs2_addr = v.vs2;
    bus.req_vd_addr  = v.vs2 + 32'h1000;
    bus.req_vl       = v.vl;
    bus.req_sew      = v.sew;
    bus.req_opsel    = v.op;
    bus.req_lop_sum  = v.lop;
    bus.req_seed     = v.seed;
    bus.req_valid    = 1'b1;
    acc = cyc + 1;
    tick();
    bus.req_valid    = 1'b0;
    bus.req_vs2_addr = '0;
    bus.req_vd_addr  = '0;
    bus.req_vl       = '0;
    bus.req_sew      = '0;
    bus.req_opsel    = '0;
    bus.req_lop_sum  = 1'b0;
    bus.req_seed     = '0;
  endtask

  task automatic run(input vec_t v);
    int acc, ro, w;
    clear_mon();
    row_val = v.row;
    drive_req(v, acc);
    ro = -1;
    if (v.n > 0) begin
      w = 0;
      while (!seen_end && w < 60) begin tick(); w++; end
      chk(v.nm, "end_seen", 64'(seen_end), 64'd1);
      repeat (v.dly) tick();
      bus.red_out_valid = 1'b1;
      ro = cyc + 1;
      tick();
      bus.red_out_valid = 1'b0;
    end
    w = 0;
    while (ndone == 0 && w < 60) begin tick(); w++; end
    repeat (3) tick();
    chk(v.nm, "done_cnt", 64'(ndone), 64'd1);
    chk(v.nm, "err_cnt", 64'(nerr), 64'(v.err));
    chk(v.nm, "done_at", 64'(done_cyc), 64'(v.n > 0 ? ro : acc));
    chk(v.nm, "ready_at_done", 64'(ready_at_done), 64'd0);
    chk(v.nm, "ready_after", 64'(bus.req_ready), 64'd1);
    chk(v.nm, "reads", 64'(nrd), 64'(v.n));
    chk(v.nm, "beats", 64'(nb), 64'(v.n));
    chk(v.nm, "idle_fields", 64'(dirty), 64'd0);
    if (v.n > 0 && nb == v.n && nrd == v.n) begin
      chk(v.nm, "rd_first", 64'(rd_first), 64'(acc));
      chk(v.nm, "beat_first", 64'(b_first), 64'(acc + 2));
      chk(v.nm, "b0_op", 64'(b0_op), 64'(v.op));
      chk(v.nm, "b0_sew", 64'(b0_sew), 64'(v.sew));
      chk(v.nm, "b0_lop", 64'(b0_lop), 64'(v.lop));
      chk(v.nm, "b0_addr", 64'(b0_addr), 64'(v.vs2 + 32'h1000));
      for (int k = 0; k < v.n; k++) begin
        chk(v.nm, $sformatf("rd_addr%0d", k), 64'(rd_addr[k]), 64'(v.vs2 + 32'(k)));
        chk(v.nm, $sformatf("start%0d", k), 64'(b_s[k]), 64'(k == 0));
        chk(v.nm, $sformatf("end%0d", k), 64'(b_e[k]), 64'(k == v.n - 1));
        chk(v.nm, $sformatf("vec1_%0d", k), b_v1[k], k == 0 ? v.seed : 64'd0);
        chk(v.nm, $sformatf("vec0_%0d", k), b_v0[k], k == v.n - 1 ? v.last : v.row);
      end
    end
  endtask

  initial begin
    int acc, w;
    vec_t rv;
    bus.req_valid     = 1'b0;
    bus.req_vs2_addr  = '0;
    bus.req_vd_addr   = '0;
    bus.req_vl        = '0;
    bus.req_sew       = '0;
    bus.req_opsel     = '0;
    bus.req_lop_sum   = 1'b0;
    bus.req_seed      = '0;
    bus.red_out_valid = 1'b0;
    clear_mon();

    //       name        vs2        vl  sew op      lop seed        row                    last beat              n err dly
    tv[0]  = '{"sum8",   32'h100,   20, 0, 3'b000, 0, 64'h5,      64'h0101010101010101, 64'h0000000001010101, 3, 0, 6};
    tv[1]  = '{"and16",  32'h200,    5, 1, 3'b001, 1, 64'hDEAD,   64'h1234123412341234, 64'hFFFFFFFFFFFF1234, 2, 0, 6};
    tv[2]  = '{"smax32", 32'h300,    3, 2, 3'b100, 0, 64'h77,     64'h1111111122222222, 64'h8000000022222222, 2, 0, 6};
    tv[3]  = '{"umin32", 32'h310,    3, 2, 3'b011, 0, 64'h78,     64'h1111111122222222, 64'hFFFFFFFF22222222, 2, 0, 6};
    tv[4]  = '{"vl0",    32'h400,    0, 0, 3'b000, 0, 64'h1,      64'h1,                64'h0,                0, 0, 0};
    tv[5]  = '{"sew3",   32'h500,    4, 3, 3'b000, 0, 64'h1,      64'h1,                64'h0,                0, 1, 0};
    tv[6]  = '{"one",    32'h600,    8, 0, 3'b000, 0, 64'hCAFE,   64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5, 1, 0, 10};
    tv[7]  = '{"smin16", 32'h700,    7, 1, 3'b010, 0, 64'h9,      64'h0102030405060708, 64'h7FFF030405060708, 2, 0, 2};
    tv[8]  = '{"ill_lop",32'h800,    4, 0, 3'b100, 1, 64'h1,      64'h1,                64'h0,                0, 1, 0};
    tv[9]  = '{"ill_ar", 32'h900,    4, 0, 3'b110, 0, 64'h1,      64'h1,                64'h0,                0, 1, 0};
    tv[10] = '{"or8",    32'hA00,    3, 0, 3'b010, 1, 64'h3,      64'hFFFFFFFFFFFFFFFF, 64'h0000000000FFFFFF, 1, 0, 0};
    tv[11] = '{"umax8",  32'hB00,    9, 0, 3'b101, 0, 64'h4,      64'h7777777777777777, 64'h0000000000000077, 2, 0, 1};

    repeat (3) tick();
    chk("reset", "outputs",
        64'({bus.req_ready, bus.busy, bus.done, bus.err, bus.rf_rd_en, bus.red_in_valid}),
        64'b100000);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run(tv[i]);

    // Reset while waiting for the result; the late retire must be dropped.
    rv = '{"rst_drain", 32'hC00, 16, 0, 3'b000, 0, 64'h1, 64'h3, 64'h3, 2, 0, 0};
    clear_mon();
    row_val = rv.row;
    drive_req(rv, acc);
    w = 0;
    while (!seen_end && w < 60) begin tick(); w++; end
    chk(rv.nm, "end_seen", 64'(seen_end), 64'd1);
    tick();
    chk(rv.nm, "busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk(rv.nm, "outputs",
        64'({bus.req_ready, bus.busy, bus.done, bus.err, bus.rf_rd_en,
             bus.red_in_valid, |bus.red_in_vec0}),
        64'b1000000);
    tick();
    rst = 1'b0;
    clear_mon();
    bus.red_out_valid = 1'b1;
    tick();
    bus.red_out_valid = 1'b0;
    repeat (5) tick();
    chk(rv.nm, "stale_done", 64'(ndone), 64'd0);
    chk(rv.nm, "stale_busy", 64'(bus.busy), 64'd0);

    run(tv[0]);
    run(tv[1]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
